cc_miss_req_unit: RTL and testbench
===================================

Name: cc_miss_req_unit

Overview:
- Upstream neighbour of the data fill unit.
- Accepts cache-miss requests from the tag-compare stage and issues one AXI AR read burst per miss, critical-word-first, 8 beats x 64 bit, WRAP.
- Pushes the matching miss address into the miss-address FIFO that the fill unit pops on the first R beat.
- Tracks outstanding bursts so that the FIFO and the memory never see more misses than the fill path can absorb.

Parameters:
- BURST_LEN, 8, beats per line fill (64 B line / 8 B beat); drives arlen = BURST_LEN-1.
- MAX_OUTSTANDING, 2, maximum AR bursts issued whose last R beat has not returned.
- ARID, 0, constant ID driven on mem_arid_o.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- miss_req_valid_i  in  1  miss request valid
- miss_req_addr_i  in  32  byte address of the missing access
- miss_req_ready_o  out  1  request accepted when valid&ready
- mem_arid_o  out  4  AR ID (= ARID)
- mem_araddr_o  out  32  burst start address, 8-byte aligned
- mem_arlen_o  out  4  BURST_LEN-1
- mem_arsize_o  out  3  3'b011 (8 B)
- mem_arburst_o  out  2  2'b10 (WRAP)
- mem_arvalid_o  out  1  AR valid
- mem_arready_i  in  1  AR ready
- mem_rvalid_i  in  1  R beat valid (monitor only)
- mem_rready_i  in  1  R beat ready (monitor only)
- mem_rlast_i  in  1  last R beat (monitor only)
- miss_addr_fifo_full_i  in  1  FIFO full
- miss_addr_fifo_wren_o  out  1  FIFO push strobe
- miss_addr_fifo_wdata_o  out  32  address pushed
- outstanding_o  out  2  current outstanding burst count
- protocol_err_o  out  1  sticky: rlast handshake seen with zero outstanding

Behaviour:
Clock, reset and state:
- One clock domain (clk). Reset is asynchronous and active-low on rst_n.
- Reset, also when asserted mid-operation: state=IDLE, all outputs 0, counter 0, err 0, latched address 0.
- Any in-flight AR is abandoned. No recovery of the partial burst.
- FSM states are IDLE and ISSUE.

IDLE:
- miss_req_ready_o = (outstanding < MAX_OUTSTANDING) & !miss_addr_fifo_full_i. This is combinational from registered state plus the full input.
- On valid&ready: latch addr_q = {miss_req_addr_i[31:3], 3'b000} and go to ISSUE.
- Bits [5:3] are kept so the WRAP burst returns the critical word first.

ISSUE:
- mem_arvalid_o=1 and mem_araddr_o=addr_q. The other AR fields are constant.
- miss_addr_fifo_wren_o=1 for exactly the first cycle of ISSUE, with wdata=addr_q. This guarantees the address is in the FIFO before any R beat of this burst can arrive.
- Stay in ISSUE with arvalid high and araddr stable until mem_arready_i=1, then return to IDLE.
- Back-to-back misses: minimum 2 cycles per request (accept in IDLE, AR handshake in ISSUE).
- miss_req_ready_o=0 while in ISSUE.

Outstanding counter:
- Increment on the AR handshake (arvalid&arready).
- Decrement on mem_rvalid_i & mem_rready_i & mem_rlast_i.
- Both in the same cycle: count unchanged.
- Decrement at 0: count stays 0 and protocol_err_o is set. It stays set until reset.
- Overflow is impossible because acceptance is gated.

FIFO full:
- Checked only at acceptance. The push cycle cannot overflow: one push per accept, and ready was gated on !full the cycle before.
- The FIFO depth must be at least MAX_OUTSTANDING. This is a checked integration rule.

Decomposition:
- Shared package cc_pkg holds:
  - AXI_BURST_WRAP = 2'b10
  - AXI_SIZE_8B = 3'b011
  - LINE_BEATS = 8
  - the state enum typedef for this block (IDLE, ISSUE), alongside the fill unit's constants.
- Single module. The outstanding counter is about 15 lines and stays inline; no sub-module.

Test Plan:
- Single miss, addr 0x0001_2368, arready held high -> ready=1 in cycle 0; cycle 1: arvalid=1, araddr=0x0001_2368, arlen=7, arburst=2, arsize=3, fifo_wren=1, wdata=0x0001_2368; outstanding=1 after cycle 1.
- Unaligned miss 0x0000_1005 with arready low for 3 cycles -> araddr=0x0000_1000 held stable for 4 cycles; fifo_wren pulses once only, in the first ISSUE cycle.
- Three back-to-back misses, MAX_OUTSTANDING=2, no R traffic -> two AR handshakes; ready=0 after the second; the third is accepted the cycle after the first rlast handshake.
- AR handshake and rlast handshake in the same cycle with outstanding=1 -> outstanding stays 1.
- miss_addr_fifo_full_i=1 with valid=1 -> ready=0 and no wren; full drops -> accept next cycle, push follows.
- Stray rlast handshake at outstanding=0 -> outstanding stays 0, protocol_err_o=1 until reset.
- Async reset asserted mid-ISSUE -> arvalid, wren and outstanding drop to 0 immediately without a clock edge.

Source files
------------

// File: rtl/cc_pkg.sv
// Shared constants and types for the cache-line miss/fill path.
// Holds the AXI encodings used by the miss request unit and the fill unit.
package cc_pkg;

  localparam logic [1:0] AXI_BURST_WRAP = 2'b10;
  localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
  localparam int         LINE_BEATS     = 8;
  localparam int         BEAT_BYTES     = 8;
  localparam int         LINE_BYTES     = LINE_BEATS * BEAT_BYTES;

  typedef enum logic {
    MRQ_IDLE  = 1'b0,
    MRQ_ISSUE = 1'b1
  } mrq_state_e;

endpackage

// File: rtl/cc_miss_req_unit.sv
// Turns tag-compare misses into critical-word-first AXI WRAP read bursts, pushes
// the miss address to the fill unit's FIFO and bounds the number of bursts in flight.
module cc_miss_req_unit
  import cc_pkg::*;
#(
  parameter int          BURST_LEN       = LINE_BEATS,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [3:0]  ARID            = 4'd0,
  parameter int          FIFO_DEPTH      = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        miss_req_valid_i,
  input  logic [31:0] miss_req_addr_i,
  output logic        miss_req_ready_o,
  output logic [3:0]  mem_arid_o,
  output logic [31:0] mem_araddr_o,
  output logic [3:0]  mem_arlen_o,
  output logic [2:0]  mem_arsize_o,
  output logic [1:0]  mem_arburst_o,
  output logic        mem_arvalid_o,
  input  logic        mem_arready_i,
  input  logic        mem_rvalid_i,
  input  logic        mem_rready_i,
  input  logic        mem_rlast_i,
  input  logic        miss_addr_fifo_full_i,
  output logic        miss_addr_fifo_wren_o,
  output logic [31:0] miss_addr_fifo_wdata_o,
  output logic [1:0]  outstanding_o,
  output logic        protocol_err_o
);

  localparam logic [1:0] MAX_CNT = 2'(MAX_OUTSTANDING);

  // Every FIFO push must find room while the bursts it tracks are in flight.
  if (FIFO_DEPTH < MAX_OUTSTANDING) begin : g_fifo_depth_check
    $error("miss address FIFO shallower than MAX_OUTSTANDING");
  end

  // Handshakes: a transfer happens in the cycle where valid and ready are both
  // high; valid never waits on ready, and payload stays stable while valid is high.
  mrq_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        first_q, first_d;
  logic [1:0]  outstanding_q, outstanding_d;
  logic        err_q, err_d;

  logic req_ready;
  logic arvalid;
  logic ar_hs;
  logic rlast_hs;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    first_d   = 1'b0;
    req_ready = 1'b0;
    arvalid   = 1'b0;
    case (state_q)
      MRQ_IDLE: begin
        req_ready = (outstanding_q < MAX_CNT) && !miss_addr_fifo_full_i;
        if (miss_req_valid_i && req_ready) begin
          // Keep bits [5:3] so the WRAP burst starts at the critical word.
          addr_d  = {miss_req_addr_i[31:3], 3'b000};
          first_d = 1'b1;
          state_d = MRQ_ISSUE;
        end
      end
      MRQ_ISSUE: begin
        arvalid = 1'b1;
        if (mem_arready_i) state_d = MRQ_IDLE;
      end
      default: state_d = MRQ_IDLE;
    endcase
  end

  assign ar_hs    = arvalid && mem_arready_i;
  assign rlast_hs = mem_rvalid_i && mem_rready_i && mem_rlast_i;

  always_comb begin
    outstanding_d = outstanding_q;
    err_d         = err_q;
    if (ar_hs && !rlast_hs) begin
      outstanding_d = outstanding_q + 2'd1;
    end else if (rlast_hs && !ar_hs) begin
      if (outstanding_q == 2'd0) err_d = 1'b1;
      else                       outstanding_d = outstanding_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= MRQ_IDLE;
      addr_q        <= 32'd0;
      first_q       <= 1'b0;
      outstanding_q <= 2'd0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      first_q       <= first_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
    end
  end

  // Ready is combinational, so it is forced low while reset is held.
  assign miss_req_ready_o       = req_ready && rst_n;
  assign mem_arid_o             = ARID;
  assign mem_araddr_o           = addr_q;
  assign mem_arlen_o            = 4'(BURST_LEN - 1);
  assign mem_arsize_o           = AXI_SIZE_8B;
  assign mem_arburst_o          = AXI_BURST_WRAP;
  assign mem_arvalid_o          = arvalid;
  assign miss_addr_fifo_wren_o  = first_q && (state_q == MRQ_ISSUE);
  assign miss_addr_fifo_wdata_o = addr_q;
  assign outstanding_o          = outstanding_q;
  assign protocol_err_o         = err_q;

endmodule

// File: tb/tb_cc_miss_req_unit.sv
// Directed bench for cc_miss_req_unit: one task per scenario, inline checks
// against hand-computed values, one summary line at the end.
module tb_cc_miss_req_unit;

  logic        clk;
  logic        rst_n;
  logic        miss_req_valid_i;
  logic [31:0] miss_req_addr_i;
  logic        miss_req_ready_o;
  logic [3:0]  mem_arid_o;
  logic [31:0] mem_araddr_o;
  logic [3:0]  mem_arlen_o;
  logic [2:0]  mem_arsize_o;
  logic [1:0]  mem_arburst_o;
  logic        mem_arvalid_o;
  logic        mem_arready_i;
  logic        mem_rvalid_i;
  logic        mem_rready_i;
  logic        mem_rlast_i;
  logic        miss_addr_fifo_full_i;
  logic        miss_addr_fifo_wren_o;
  logic [31:0] miss_addr_fifo_wdata_o;
  logic [1:0]  outstanding_o;
  logic        protocol_err_o;

  int chk_cnt;
  int pass_cnt;

  cc_miss_req_unit dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .miss_req_valid_i       (miss_req_valid_i),
    .miss_req_addr_i        (miss_req_addr_i),
    .miss_req_ready_o       (miss_req_ready_o),
    .mem_arid_o             (mem_arid_o),
    .mem_araddr_o           (mem_araddr_o),
    .mem_arlen_o            (mem_arlen_o),
    .mem_arsize_o           (mem_arsize_o),
    .mem_arburst_o          (mem_arburst_o),
    .mem_arvalid_o          (mem_arvalid_o),
    .mem_arready_i          (mem_arready_i),
    .mem_rvalid_i           (mem_rvalid_i),
    .mem_rready_i           (mem_rready_i),
    .mem_rlast_i            (mem_rlast_i),
    .miss_addr_fifo_full_i  (miss_addr_fifo_full_i),
    .miss_addr_fifo_wren_o  (miss_addr_fifo_wren_o),
    .miss_addr_fifo_wdata_o (miss_addr_fifo_wdata_o),
    .outstanding_o          (outstanding_o),
    .protocol_err_o         (protocol_err_o)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to 1 time unit after the next rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Inputs are driven at edge+1; outputs are sampled at edge+2.
  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    miss_req_valid_i      = 1'b0;
    miss_req_addr_i       = 32'd0;
    mem_arready_i         = 1'b0;
    mem_rvalid_i          = 1'b0;
    mem_rready_i          = 1'b0;
    mem_rlast_i           = 1'b0;
    miss_addr_fifo_full_i = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    next_cycle();
  endtask

  // One rlast handshake lasting one cycle.
  task automatic rlast_beat();
    mem_rvalid_i = 1'b1;
    mem_rready_i = 1'b1;
    mem_rlast_i  = 1'b1;
    next_cycle();
    mem_rvalid_i = 1'b0;
    mem_rready_i = 1'b0;
    mem_rlast_i  = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #3;
    chk_cnt++;
    if ({mem_arvalid_o, miss_addr_fifo_wren_o, miss_req_ready_o, outstanding_o, protocol_err_o} !== 6'd0)
      $display("FAIL reset_outputs got=%b want=000000",
               {mem_arvalid_o, miss_addr_fifo_wren_o, miss_req_ready_o, outstanding_o, protocol_err_o});
    else pass_cnt++;
    chk_cnt++;
    if (mem_araddr_o !== 32'd0) $display("FAIL reset_araddr got=%h want=0", mem_araddr_o);
    else pass_cnt++;
    do_reset();
    chk_cnt++;
    if (miss_req_ready_o !== 1'b1) $display("FAIL reset_ready_after got=%b want=1", miss_req_ready_o);
    else pass_cnt++;
  endtask

  task automatic test_single_miss();
    miss_req_valid_i = 1'b1;
    miss_req_addr_i  = 32'h0001_2368;
    mem_arready_i    = 1'b1;
    settle();
    chk_cnt++;
    if (miss_req_ready_o !== 1'b1) $display("FAIL single_ready got=%b want=1", miss_req_ready_o);
    else pass_cnt++;
    next_cycle();
    miss_req_valid_i = 1'b0;
    settle();
    chk_cnt++;
    if ({mem_arvalid_o, mem_araddr_o, mem_arlen_o, mem_arburst_o, mem_arsize_o, mem_arid_o}
        !== {1'b1, 32'h0001_2368, 4'd7, 2'd2, 3'd3, 4'd0})
      $display("FAIL single_ar got=%b/%h/%0d/%0d/%0d/%0d want=1/00012368/7/2/3/0",
               mem_arvalid_o, mem_araddr_o, mem_arlen_o, mem_arburst_o, mem_arsize_o, mem_arid_o);
    else pass_cnt++;
    chk_cnt++;
    if ({miss_addr_fifo_wren_o, miss_addr_fifo_wdata_o} !== {1'b1, 32'h0001_2368})
      $display("FAIL single_push got=%b/%h want=1/00012368", miss_addr_fifo_wren_o, miss_addr_fifo_wdata_o);
    else pass_cnt++;
    chk_cnt++;
    if (miss_req_ready_o !== 1'b0) $display("FAIL single_ready_issue got=%b want=0", miss_req_ready_o);
    else pass_cnt++;
    next_cycle();
    mem_arready_i = 1'b0;
    settle();
    chk_cnt++;
    if ({outstanding_o, mem_arvalid_o, miss_addr_fifo_wren_o} !== {2'd1, 1'b0, 1'b0})
      $display("FAIL single_after got=%0d/%b/%b want=1/0/0", outstanding_o, mem_arvalid_o, miss_addr_fifo_wren_o);
    else pass_cnt++;
    rlast_beat();
    settle();
    chk_cnt++;
    if (outstanding_o !== 2'd0) $display("FAIL single_drain got=%0d want=0", outstanding_o);
    else pass_cnt++;
  endtask

  task automatic test_unaligned_stall();
    int wren_seen;
    wren_seen = 0;
    miss_req_valid_i = 1'b1;
    miss_req_addr_i  = 32'h0000_1005;
    mem_arready_i    = 1'b0;
    next_cycle();
    miss_req_valid_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      mem_arready_i = (c == 3);
      settle();
      chk_cnt++;
      if ({mem_arvalid_o, mem_araddr_o} !== {1'b1, 32'h0000_1000})
        $display("FAIL stall_ar_c%0d got=%b/%h want=1/00001000", c, mem_arvalid_o, mem_araddr_o);
      else pass_cnt++;
      chk_cnt++;
      if (miss_addr_fifo_wren_o !== (c == 0))
        $display("FAIL stall_wren_c%0d got=%b want=%b", c, miss_addr_fifo_wren_o, (c == 0));
      else pass_cnt++;
      if (miss_addr_fifo_wren_o === 1'b1) wren_seen++;
      next_cycle();
    end
    mem_arready_i = 1'b0;
    settle();
    chk_cnt++;
    if ({wren_seen, outstanding_o, mem_arvalid_o} !== {32'd1, 2'd1, 1'b0})
      $display("FAIL stall_end got=%0d/%0d/%b want=1/1/0", wren_seen, outstanding_o, mem_arvalid_o);
    else pass_cnt++;
    rlast_beat();
  endtask

  task automatic test_back_to_back();
    int ar_hs;
    ar_hs = 0;
    mem_arready_i    = 1'b1;
    miss_req_valid_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      miss_req_addr_i = 32'h0000_2000 + 32'(c) * 32'h40;
      settle();
      if (mem_arvalid_o === 1'b1) ar_hs++;
      next_cycle();
    end
    // Two bursts issued, the third request is now blocked.
    settle();
    chk_cnt++;
    if ({ar_hs, outstanding_o, miss_req_ready_o} !== {32'd2, 2'd2, 1'b0})
      $display("FAIL b2b_limit got=%0d/%0d/%b want=2/2/0", ar_hs, outstanding_o, miss_req_ready_o);
    else pass_cnt++;
    miss_req_addr_i = 32'h0000_3008;
    rlast_beat();
    settle();
    chk_cnt++;
    if ({outstanding_o, miss_req_ready_o} !== {2'd1, 1'b1})
      $display("FAIL b2b_reopen got=%0d/%b want=1/1", outstanding_o, miss_req_ready_o);
    else pass_cnt++;
    next_cycle();
    miss_req_valid_i = 1'b0;
    settle();
    chk_cnt++;
    if ({mem_arvalid_o, mem_araddr_o, miss_addr_fifo_wren_o} !== {1'b1, 32'h0000_3008, 1'b1})
      $display("FAIL b2b_third got=%b/%h/%b want=1/00003008/1", mem_arvalid_o, mem_araddr_o, miss_addr_fifo_wren_o);
    else pass_cnt++;
    next_cycle();
    mem_arready_i = 1'b0;
    settle();
    chk_cnt++;
    if (outstanding_o !== 2'd2) $display("FAIL b2b_third_cnt got=%0d want=2", outstanding_o);
    else pass_cnt++;
    rlast_beat();
  endtask

  task automatic test_simultaneous();
    // Entry: outstanding = 1.
    miss_req_valid_i = 1'b1;
    miss_req_addr_i  = 32'h0000_4010;
    next_cycle();
    miss_req_valid_i = 1'b0;
    mem_arready_i    = 1'b1;
    mem_rvalid_i     = 1'b1;
    mem_rready_i     = 1'b1;
    mem_rlast_i      = 1'b1;
    next_cycle();
    idle_inputs();
    settle();
    chk_cnt++;
    if ({outstanding_o, protocol_err_o} !== {2'd1, 1'b0})
      $display("FAIL simul_cnt got=%0d/%b want=1/0", outstanding_o, protocol_err_o);
    else pass_cnt++;
    rlast_beat();
    settle();
    chk_cnt++;
    if (outstanding_o !== 2'd0) $display("FAIL simul_drain got=%0d want=0", outstanding_o);
    else pass_cnt++;
  endtask

  task automatic test_fifo_full();
    miss_req_valid_i      = 1'b1;
    miss_req_addr_i       = 32'h0000_5028;
    miss_addr_fifo_full_i = 1'b1;
    mem_arready_i         = 1'b1;
    settle();
    chk_cnt++;
    if (miss_req_ready_o !== 1'b0) $display("FAIL full_ready got=%b want=0", miss_req_ready_o);
    else pass_cnt++;
    next_cycle();
    miss_addr_fifo_full_i = 1'b0;
    settle();
    chk_cnt++;
    if ({miss_addr_fifo_wren_o, mem_arvalid_o, miss_req_ready_o} !== {1'b0, 1'b0, 1'b1})
      $display("FAIL full_release got=%b/%b/%b want=0/0/1", miss_addr_fifo_wren_o, mem_arvalid_o, miss_req_ready_o);
    else pass_cnt++;
    next_cycle();
    miss_req_valid_i = 1'b0;
    settle();
    chk_cnt++;
    if ({miss_addr_fifo_wren_o, miss_addr_fifo_wdata_o} !== {1'b1, 32'h0000_5028})
      $display("FAIL full_push got=%b/%h want=1/00005028", miss_addr_fifo_wren_o, miss_addr_fifo_wdata_o);
    else pass_cnt++;
    next_cycle();
    mem_arready_i = 1'b0;
    rlast_beat();
  endtask

  task automatic test_stray_rlast();
    settle();
    chk_cnt++;
    if ({outstanding_o, protocol_err_o} !== {2'd0, 1'b0})
      $display("FAIL stray_pre got=%0d/%b want=0/0", outstanding_o, protocol_err_o);
    else pass_cnt++;
    rlast_beat();
    repeat (3) next_cycle();
    chk_cnt++;
    if ({outstanding_o, protocol_err_o} !== {2'd0, 1'b1})
      $display("FAIL stray_err got=%0d/%b want=0/1", outstanding_o, protocol_err_o);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    // Build outstanding = 1, then stall a second burst in ISSUE.
    mem_arready_i    = 1'b1;
    miss_req_valid_i = 1'b1;
    miss_req_addr_i  = 32'h0000_6000;
    next_cycle();
    miss_req_valid_i = 1'b0;
    next_cycle();
    mem_arready_i    = 1'b0;
    miss_req_valid_i = 1'b1;
    miss_req_addr_i  = 32'h0000_7038;
    next_cycle();
    miss_req_valid_i = 1'b0;
    settle();
    chk_cnt++;
    if ({mem_arvalid_o, miss_addr_fifo_wren_o, outstanding_o, protocol_err_o} !== {1'b1, 1'b1, 2'd1, 1'b1})
      $display("FAIL arst_pre got=%b/%b/%0d/%b want=1/1/1/1",
               mem_arvalid_o, miss_addr_fifo_wren_o, outstanding_o, protocol_err_o);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    chk_cnt++;
    if ({mem_arvalid_o, miss_addr_fifo_wren_o, outstanding_o, protocol_err_o, miss_req_ready_o} !== 6'd0)
      $display("FAIL arst_drop got=%b/%b/%0d/%b/%b want=0/0/0/0/0",
               mem_arvalid_o, miss_addr_fifo_wren_o, outstanding_o, protocol_err_o, miss_req_ready_o);
    else pass_cnt++;
    chk_cnt++;
    if (mem_araddr_o !== 32'd0) $display("FAIL arst_addr got=%h want=0", mem_araddr_o);
    else pass_cnt++;
    do_reset();
    settle();
    chk_cnt++;
    if ({miss_req_ready_o, mem_arvalid_o, outstanding_o} !== {1'b1, 1'b0, 2'd0})
      $display("FAIL arst_after got=%b/%b/%0d want=1/0/0", miss_req_ready_o, mem_arvalid_o, outstanding_o);
    else pass_cnt++;
  endtask

  initial begin
    chk_cnt  = 0;
    pass_cnt = 0;
    idle_inputs();
    rst_n = 1'b1;
    test_reset();
    test_single_miss();
    test_unaligned_stall();
    test_back_to_back();
    test_simultaneous();
    test_fifo_full();
    test_stray_rlast();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
